adc_interface: RTL and testbench
================================

ADC_INTERFACE -- requirements
Module: adc_interface

Interface
REQ-001 Parameters: none; timing constants come from adc_interface_pkg (REQ-022).
REQ-002 clk  in  1  ADC-domain clock, nominal 1.5625 MHz (system clock / 32).
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 chan  in  3  single-ended input channel to request, 0..7.
REQ-005 ADC_SDO  in  1  serial conversion data from the LTC2308, MSB first.
REQ-006 result  out  12  last completed conversion, unsigned straight binary.
REQ-007 ADC_CONVST  out  1  conversion start to the ADC.
REQ-008 ADC_SCK  out  1  serial clock to the ADC.
REQ-009 ADC_SDI  out  1  serial 6-bit configuration word to the ADC.
REQ-010 One clock (clk); reset_n asynchronous, active-low; every output is a flop on clk rising edge, no gated or combinational outputs.

Function
REQ-011 The FSM repeats a 29-cycle frame: CONV (1 cycle), WAIT (3 cycles), SHIFT (24 cycles), DONE (1 cycle), then CONV.
REQ-012 CONV: ADC_CONVST=1 and chan is latched into chan_q; ADC_CONVST=0 in all other states.
REQ-013 WAIT: ADC_SCK=0, ADC_SDI=0; 3 cycles (1.92 us) cover the 1.6 us maximum conversion time.
REQ-014 SHIFT: 12 bit slots of 2 cycles each; slot k (k=0..11) drives ADC_SCK=0 in the first cycle and ADC_SCK=1 in the second.
REQ-015 Config word, sent MSB first in slots 0..5: S/D=1, O/S=chan_q[0], S1=chan_q[2], S0=chan_q[1], UNI=1, SLP=0; slots 6..11 drive ADC_SDI=0.
REQ-016 ADC_SDI for slot k is set on entry to the slot's low cycle and held through its high cycle.
REQ-017 ADC_SDO is sampled on the clk edge that drives ADC_SCK from 0 to 1, into shift register bit 11-k (MSB first).
REQ-018 DONE: ADC_SCK=0, ADC_SDI=0; result is loaded from the 12-bit shift register and holds its value until the next DONE.
REQ-019 Pipeline: the ADC applies a config word to the next conversion, so the result loaded at the end of frame N is the channel latched in frame N-1; the first result after reset converts ADC default channel 0.
REQ-020 A chan change mid-frame has no effect until the next CONV.

Reset
REQ-021 While reset_n=0: FSM=CONV with cycle count 0, ADC_CONVST=0, ADC_SCK=0, ADC_SDI=0, result=12'h000, shift register=0, chan_q=0. After release, the first clk edge enters CONV with ADC_CONVST=1. Reset asserted mid-frame aborts the frame and leaves result=0.

Structure
REQ-022 adc_interface_pkg holds: state enum {CONV, WAIT, SHIFT, DONE}, WAIT_CYCLES=3, NBITS=12, CFG_BITS=6, FRAME_CYCLES=29.
REQ-023 Single flat module; no sub-module required. A 5-bit cycle counter plus the state register is sufficient.
REQ-024 The display decoders decode2 and decode7 are separate blocks and are not part of this module.

Verification
REQ-025 Reset released, ADC model idle -> ADC_CONVST high exactly 1 cycle, period 29 cycles; exactly 12 ADC_SCK rising edges per frame, none in WAIT or DONE.
REQ-026 chan=5 held -> SDI word over first 6 SCK rises = 1,1,1,0,1,0 (S/D,O/S,S1,S0,UNI,SLP), then 6 zeros.
REQ-027 ADC model returns 12'hA5C MSB first, changing SDO only after SCK falls -> result=12'hA5C one cycle after the frame's last SCK high cycle, stable for 29 cycles.
REQ-028 chan switched 0->3 between frames, model returns the requested channel's value (ch0=12'h100, ch3=12'h7FF) -> first frame after the switch still yields 12'h100, next yields 12'h7FF.
REQ-029 Boundary data 12'h000 and 12'hFFF -> result exact, no bit loss at MSB/LSB.
REQ-030 reset_n pulsed low during SHIFT slot 6 -> outputs 0 immediately (asynchronous), result=0, clean CONV on release, no partial result published.

Source files
------------

// File: rtl/adc_interface_pkg.sv
// Shared types and timing constants for the LTC2308 serial ADC interface.
//   state_e      : frame phases CONV -> WAIT -> SHIFT -> DONE -> CONV
//   WAIT_CYCLES  : clk cycles that cover the worst-case conversion time
//   NBITS        : conversion width, also the number of SCK pulses per frame
//   CFG_BITS     : width of the configuration word sent on SDI
//   FRAME_CYCLES : total clk cycles per frame
//   cfg_word()   : builds the SDI configuration word for a single-ended channel
package adc_interface_pkg;

  typedef enum logic [1:0] {CONV, WAIT, SHIFT, DONE} state_e;

  localparam int unsigned WAIT_CYCLES  = 3;
  localparam int unsigned NBITS        = 12;
  localparam int unsigned CFG_BITS     = 6;
  localparam int unsigned FRAME_CYCLES = 29;

  // Each bit slot takes one low and one high SCK cycle.
  localparam int unsigned SHIFT_CYCLES = 2 * NBITS;

  // Wide enough to count the longest phase inside a frame.
  localparam int unsigned CNT_W = $clog2(FRAME_CYCLES);

  // Word order on the wire, MSB first: S/D, O/S, S1, S0, UNI, SLP.
  // Single-ended, unipolar, no sleep; channel bits are scrambled by the LTC2308 map.
  function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
  endfunction

endpackage

// File: rtl/adc_interface.sv
// Free-running LTC2308 conversion sequencer. Every frame it pulses CONVST, waits out
// the conversion, then clocks 12 bits: the next channel's configuration goes out on
// SDI while the previous conversion comes back on SDO.
//   clk        : ADC-domain clock
//   reset_n    : asynchronous active-low reset
//   chan       : single-ended channel to request, sampled at the start of each frame
//   ADC_SDO    : serial data from the ADC, MSB first
//   result     : last completed conversion, updated once per frame
//   ADC_CONVST : conversion start strobe
//   ADC_SCK    : serial clock to the ADC
//   ADC_SDI    : serial configuration data to the ADC
module adc_interface
  import adc_interface_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       chan,
  input  logic             ADC_SDO,
  output logic [NBITS-1:0] result,
  output logic             ADC_CONVST,
  output logic             ADC_SCK,
  output logic             ADC_SDI
);

  localparam logic [CNT_W-1:0] WaitLast  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ShiftLast = CNT_W'(SHIFT_CYCLES - 1);
  localparam logic [CNT_W-2:0] CfgSlots  = (CNT_W-1)'(CFG_BITS);

  // state_q/cnt_q name the cycle the outputs will show after the next edge; all
  // outputs are registered from them, so reset (CONV, 0) yields a CONVST pulse on
  // the first edge after release.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]          chan_q;
  logic [NBITS-1:0]    shift_q;
  logic [CFG_BITS-1:0] cfg;
  logic [CNT_W-2:0]    slot;
  logic [2:0]          cfg_idx;

  logic convst_d, sck_d, sdi_d;
  logic latch_chan, sample, load;

  assign cfg     = cfg_word(chan_q);
  assign slot    = cnt_q[CNT_W-1:1];
  assign cfg_idx = 3'(CFG_BITS - 1) - slot[2:0];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CONV;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      CONV: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q == WaitLast) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == ShiftLast) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = CONV;
        cnt_d   = '0;
      end
      default: begin
        state_d = CONV;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode; these are next values for the registered pins.
  always_comb begin
    convst_d   = 1'b0;
    sck_d      = 1'b0;
    sdi_d      = 1'b0;
    latch_chan = 1'b0;
    sample     = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      CONV: begin
        convst_d   = 1'b1;
        latch_chan = 1'b1;
      end
      WAIT: begin
      end
      SHIFT: begin
        // cnt_q[0] picks the high half of the slot; SDI is the same in both halves.
        sck_d  = cnt_q[0];
        sample = cnt_q[0];
        if (slot < CfgSlots) begin
          sdi_d = cfg[cfg_idx];
        end
      end
      DONE: begin
        load = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Output pins and datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ADC_CONVST <= 1'b0;
      ADC_SCK    <= 1'b0;
      ADC_SDI    <= 1'b0;
      chan_q     <= '0;
      shift_q    <= '0;
      result     <= '0;
    end else begin
      ADC_CONVST <= convst_d;
      ADC_SCK    <= sck_d;
      ADC_SDI    <= sdi_d;
      if (latch_chan) begin
        chan_q <= chan;
      end
      // SDO is sampled on the edge that raises SCK; after 12 shifts bit 11 holds the MSB.
      if (sample) begin
        shift_q <= {shift_q[NBITS-2:0], ADC_SDO};
      end
      if (load) begin
        result <= shift_q;
      end
    end
  end

endmodule

// File: tb/tb_adc_interface.sv
// Directed bench for adc_interface with a small LTC2308 behavioural model.
// Frame index 0 is the cycle where CONVST is high; index 28 is the DONE cycle.
module tb_adc_interface;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  chan = 3'd0;
  logic        ADC_SDO;
  logic [11:0] result;
  logic        ADC_CONVST;
  logic        ADC_SCK;
  logic        ADC_SDI;

  int total = 0;
  int bad   = 0;

  adc_interface dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chan       (chan),
    .ADC_SDO    (ADC_SDO),
    .result     (result),
    .ADC_CONVST (ADC_CONVST),
    .ADC_SCK    (ADC_SCK),
    .ADC_SDI    (ADC_SDI)
  );

  always #5 clk = ~clk;

  // ADC model: per-channel conversion values; the config captured during one frame
  // selects the value returned in the next frame. SDO advances only after SCK falls.
  logic [11:0] mem [8];
  logic [11:0] word;
  logic [5:0]  sdi_sh;
  logic [3:0]  rises;
  logic [3:0]  bitn;
  logic [3:0]  sdo_idx;
  logic        sck_prev;

  assign sdo_idx = 4'd11 - bitn;
  assign ADC_SDO = (bitn < 4'd12) ? word[sdo_idx] : 1'b0;

  always @(negedge clk) begin
    sck_prev <= ADC_SCK;
    if (!reset_n) begin
      word   <= 12'h000;
      sdi_sh <= 6'b0;
      rises  <= 4'd0;
      bitn   <= 4'd12;
    end else if (ADC_CONVST) begin
      // Channel = {S1, S0, O/S} from the previous frame's config word.
      word  <= mem[{sdi_sh[3], sdi_sh[2], sdi_sh[4]}];
      rises <= 4'd0;
      bitn  <= 4'd0;
    end else begin
      if (ADC_SCK && !sck_prev) begin
        if (rises < 4'd6) sdi_sh <= {sdi_sh[4:0], ADC_SDI};
        rises <= rises + 4'd1;
      end
      if (!ADC_SCK && sck_prev) bitn <= bitn + 4'd1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1);
  end

  // Advance to the next CONVST cycle (bounded).
  task automatic wait_conv(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ADC_CONVST !== 1'b1 && n < 40);
    total++;
    if (ADC_CONVST !== 1'b1) begin
      bad++;
      $display("FAIL %s_conv_timeout: CONVST=%b after %0d cycles, required 1", tag, ADC_CONVST, n);
    end
  endtask

  // Change model data mid-cycle so it never races the model's negedge update.
  task automatic set_mem_all(input logic [11:0] v);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) mem[i] = v;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 8; i++) mem[i] = 12'h555;
    mem[0]  = 12'h0AB;
    chan    = 3'd5;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ADC_CONVST !== 1'b0) begin bad++; $display("FAIL rst_convst: got %b want 0", ADC_CONVST); end
    total++; if (ADC_SCK !== 1'b0) begin bad++; $display("FAIL rst_sck: got %b want 0", ADC_SCK); end
    total++; if (ADC_SDI !== 1'b0) begin bad++; $display("FAIL rst_sdi: got %b want 0", ADC_SDI); end
    total++; if (result !== 12'h000) begin bad++; $display("FAIL rst_result: got %h want 000", result); end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (ADC_CONVST !== 1'b1) begin bad++; $display("FAIL rst_first_conv: got %b want 1", ADC_CONVST); end
  endtask

  // Two full frames from the first CONV: CONVST/SCK timing, SCK count, first results.
  task automatic test_frame;
    int   j;
    int   nrise;
    logic prev;
    logic exp_sck;
    nrise = 0;
    prev  = 1'b0;
    for (int i = 0; i < 58; i++) begin
      if (i > 0) @(negedge clk);
      j = i % 29;
      exp_sck = (j >= 5 && j <= 27 && (j % 2 == 1));
      total++;
      if (ADC_CONVST !== (j == 0)) begin
        bad++; $display("FAIL frame_convst[%0d]: got %b want %b", i, ADC_CONVST, (j == 0));
      end
      total++;
      if (ADC_SCK !== exp_sck) begin
        bad++; $display("FAIL frame_sck[%0d]: got %b want %b", i, ADC_SCK, exp_sck);
      end
      if (j <= 3 || j == 28) begin
        total++;
        if (ADC_SDI !== 1'b0) begin bad++; $display("FAIL frame_sdi_idle[%0d]: got %b want 0", i, ADC_SDI); end
      end
      if (ADC_SCK === 1'b1 && prev === 1'b0) nrise++;
      prev = ADC_SCK;
      if (j == 27 && i < 29) begin
        total++;
        if (result !== 12'h000) begin bad++; $display("FAIL frame_result_early: got %h want 000", result); end
      end
      if (j == 28) begin
        total++;
        if (nrise != 12) begin bad++; $display("FAIL frame_sck_rises[%0d]: got %0d want 12", i, nrise); end
        nrise = 0;
        total++;
        if (i < 29 && result !== 12'h0AB) begin
          bad++; $display("FAIL frame_default_ch0: got %h want 0AB", result);
        end else if (i >= 29 && result !== 12'h555) begin
          bad++; $display("FAIL frame_ch5_result: got %h want 555", result);
        end
      end
    end
  endtask

  task automatic test_cfg_word;
    logic [11:0] exp_bits;
    int k;
    exp_bits = 12'b111010_000000;
    chan = 3'd5;
    wait_conv("cfg");
    for (int i = 1; i <= 28; i++) begin
      @(negedge clk);
      if (i >= 4 && i <= 27) begin
        k = (i - 4) / 2;
        total++;
        if (ADC_SDI !== exp_bits[11-k]) begin
          bad++; $display("FAIL cfg_sdi_slot%0d_idx%0d: got %b want %b", k, i, ADC_SDI, exp_bits[11-k]);
        end
      end
    end
  endtask

  task automatic test_data;
    set_mem_all(12'hA5C);
    wait_conv("data");
    repeat (27) @(negedge clk);
    total++; if (result !== 12'h555) begin bad++; $display("FAIL data_before_done: got %h want 555", result); end
    @(negedge clk);
    total++; if (result !== 12'hA5C) begin bad++; $display("FAIL data_a5c: got %h want a5c", result); end
    for (int i = 1; i <= 28; i++) begin
      @(negedge clk);
      total++;
      if (result !== 12'hA5C) begin bad++; $display("FAIL data_hold[%0d]: got %h want a5c", i, result); end
    end
  endtask

  task automatic test_boundary;
    set_mem_all(12'h000);
    wait_conv("zero");
    repeat (28) @(negedge clk);
    total++; if (result !== 12'h000) begin bad++; $display("FAIL bound_000: got %h want 000", result); end
    set_mem_all(12'hFFF);
    wait_conv("ones");
    repeat (27) @(negedge clk);
    total++; if (result !== 12'h000) begin bad++; $display("FAIL bound_pre_fff: got %h want 000", result); end
    @(negedge clk);
    total++; if (result !== 12'hFFF) begin bad++; $display("FAIL bound_fff: got %h want fff", result); end
  endtask

  task automatic test_pipeline;
    chan = 3'd0;
    set_mem_all(12'h321);
    mem[0] = 12'h100;
    mem[3] = 12'h7FF;
    wait_conv("pipe_a");
    @(negedge clk);
    chan = 3'd3;  // mid-frame change: must not alter this frame's config
    repeat (27) @(negedge clk);
    total++; if (result !== 12'h321) begin bad++; $display("FAIL pipe_prev_ch5: got %h want 321", result); end
    wait_conv("pipe_b");
    repeat (28) @(negedge clk);
    total++; if (result !== 12'h100) begin bad++; $display("FAIL pipe_ch0: got %h want 100", result); end
    wait_conv("pipe_c");
    repeat (28) @(negedge clk);
    total++; if (result !== 12'h7FF) begin bad++; $display("FAIL pipe_ch3: got %h want 7ff", result); end
  endtask

  task automatic test_reset_mid;
    set_mem_all(12'h9C3);
    wait_conv("mid");
    repeat (17) @(negedge clk);  // slot 6 high cycle
    total++; if (ADC_SCK !== 1'b1) begin bad++; $display("FAIL mid_sck_before: got %b want 1", ADC_SCK); end
    #1 reset_n = 1'b0;
    #1;
    total++; if (ADC_SCK !== 1'b0) begin bad++; $display("FAIL mid_sck_async: got %b want 0", ADC_SCK); end
    total++; if (ADC_CONVST !== 1'b0) begin bad++; $display("FAIL mid_convst_async: got %b want 0", ADC_CONVST); end
    total++; if (ADC_SDI !== 1'b0) begin bad++; $display("FAIL mid_sdi_async: got %b want 0", ADC_SDI); end
    total++; if (result !== 12'h000) begin bad++; $display("FAIL mid_result_async: got %h want 000", result); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (ADC_CONVST !== 1'b1) begin bad++; $display("FAIL mid_clean_conv: got %b want 1", ADC_CONVST); end
    repeat (27) @(negedge clk);
    total++; if (result !== 12'h000) begin bad++; $display("FAIL mid_no_partial: got %h want 000", result); end
    @(negedge clk);
    total++; if (result !== 12'h9C3) begin bad++; $display("FAIL mid_after_reset: got %h want 9c3", result); end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_cfg_word;
    test_data;
    test_boundary;
    test_pipeline;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
